// File: rtl/contador_bcd_asc_lim_pkg.sv
// Shared BCD definitions and helpers for the ascending limited BCD counter.
package contador_bcd_asc_lim_pkg;

    localparam int unsigned  BCD_W   = 4;
    localparam logic [3:0]   BCD_MAX = 4'd9;

    function automatic logic bcd_digit_valid(input logic [BCD_W-1:0] d);
        return (d <= BCD_MAX);
    endfunction

    // True when the two-digit BCD value {a_t,a_u} is less than or equal to {b_t,b_u}.
    function automatic logic bcd_le(input logic [BCD_W-1:0] a_t,
                                    input logic [BCD_W-1:0] a_u,
                                    input logic [BCD_W-1:0] b_t,
                                    input logic [BCD_W-1:0] b_u);
        return (a_t < b_t) || ((a_t == b_t) && (a_u <= b_u));
    endfunction

endpackage

// File: rtl/contador_bcd_digito.sv
// Single BCD digit register: clear, parallel load, and 9 -> 0 wrapping increment.
module contador_bcd_digito
    import contador_bcd_asc_lim_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic             ld,
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q,
    output logic             at9
);

    logic [BCD_W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= '0;
        end else if (clr) begin
            q_reg <= '0;
        end else if (ld) begin
            q_reg <= d;
        end else if (inc) begin
            q_reg <= (q_reg == BCD_MAX) ? '0 : q_reg + 4'd1;
        end
    end

    assign q   = q_reg;
    assign at9 = (q_reg == BCD_MAX);

endmodule

// File: rtl/contador_bcd_asc_lim.sv
// Two-digit BCD up-counter wrapping at {MAX_TENS,MAX_UNITS}, with validated load and cascade carry.
module contador_bcd_asc_lim
    import contador_bcd_asc_lim_pkg::*;
#(
    parameter int unsigned MAX_TENS  = 5,
    parameter int unsigned MAX_UNITS = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [BCD_W-1:0] load_tens,
    input  logic [BCD_W-1:0] load_units,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] units,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [BCD_W-1:0] LIM_T = BCD_W'(MAX_TENS);
    localparam logic [BCD_W-1:0] LIM_U = BCD_W'(MAX_UNITS);

    // Index 0 is the units digit, index 1 the tens digit.
    logic [BCD_W-1:0] dig_q   [2];
    logic [BCD_W-1:0] dig_d   [2];
    logic             dig_at9 [2];
    logic             dig_inc [2];
    logic [2:0]       carry;

    logic at_limit;
    logic wrap_hit;
    logic load_ok;
    logic load_accept;
    logic count_step;
    logic wrap_next;
    logic load_err_next;
    logic wrap_reg;
    logic load_err_reg;

    assign dig_d[0] = load_units;
    assign dig_d[1] = load_tens;
    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_digit
            assign carry[gi+1]  = carry[gi] & dig_at9[gi];
            assign dig_inc[gi]  = count_step & carry[gi];

            contador_bcd_digito u_digit (
                .clk   (clk),
                .reset (reset),
                .inc   (dig_inc[gi]),
                .clr   (wrap_next),
                .ld    (load_accept),
                .d     (dig_d[gi]),
                .q     (dig_q[gi]),
                .at9   (dig_at9[gi])
            );
        end
    endgenerate

    // 99 can only be reached when it is the limit, so all-nines rolling over is harmless.
    always_comb begin
        at_limit      = (dig_q[1] == LIM_T) && (dig_q[0] == LIM_U);
        wrap_hit      = at_limit | carry[2];
        load_ok       = bcd_digit_valid(load_tens) && bcd_digit_valid(load_units) &&
                        bcd_le(load_tens, load_units, LIM_T, LIM_U);
        load_accept   = load & load_ok;
        count_step    = enable & ~load & ~wrap_hit;
        wrap_next     = enable & ~load & wrap_hit;
        load_err_next = load & ~load_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_reg     <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            wrap_reg     <= wrap_next;
            load_err_reg <= load_err_next;
        end
    end

    assign tens     = dig_q[1];
    assign units    = dig_q[0];
    assign tc       = enable & wrap_hit;
    assign wrap     = wrap_reg;
    assign load_err = load_err_reg;

endmodule

// File: tb/tb_contador_bcd_asc_lim.sv
// Scoreboard bench: default 59-limit instance plus a 35-limit instance, checked against a decimal model.
module tb_contador_bcd_asc_lim;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, ld_a, rst_b, en_b, ld_b;
    logic [3:0] lt_a, lu_a, lt_b, lu_b;
    logic [3:0] tens_a, units_a, tens_b, units_b;
    logic       tc_a, wrap_a, lerr_a, tc_b, wrap_b, lerr_b;

    contador_bcd_asc_lim dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .load(ld_a),
        .load_tens(lt_a), .load_units(lu_a),
        .tens(tens_a), .units(units_a), .tc(tc_a), .wrap(wrap_a), .load_err(lerr_a)
    );

    contador_bcd_asc_lim #(.MAX_TENS(3), .MAX_UNITS(5)) dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b), .load(ld_b),
        .load_tens(lt_b), .load_units(lu_b),
        .tens(tens_b), .units(units_b), .tc(tc_b), .wrap(wrap_b), .load_err(lerr_b)
    );

    typedef struct {
        int id;
        int t;
        int u;
        bit w;
        bit le;
    } exp_t;

    exp_t sb_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   m_val [2]  = '{0, 0};
    int   m_lim [2]  = '{59, 35};
    bit   m_known [2] = '{1'b0, 1'b0};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus on DUT `id`; the other instance idles.
    task automatic apply(input int id, input bit r, input bit e, input bit l,
                         input logic [3:0] t, input logic [3:0] u);
        exp_t x;
        bit   tc_exp;
        int   lv;
        if (id == 0) begin
            rst_a = r; en_a = e; ld_a = l; lt_a = t; lu_a = u;
            rst_b = 0; en_b = 0; ld_b = 0; lt_b = 0; lu_b = 0;
        end else begin
            rst_b = r; en_b = e; ld_b = l; lt_b = t; lu_b = u;
            rst_a = 0; en_a = 0; ld_a = 0; lt_a = 0; lu_a = 0;
        end
        #1;
        tc_exp = e && (m_val[id] == m_lim[id]);
        if (m_known[id])
            check($sformatf("tc[%0d]", id), 8'((id == 0) ? tc_a : tc_b), 8'(tc_exp));
        x.id = id; x.w = 0; x.le = 0;
        lv = int'(t) * 10 + int'(u);
        if (r) begin
            m_val[id] = 0;
            m_known[id] = 1'b1;
        end else if (l) begin
            if (t <= 9 && u <= 9 && lv <= m_lim[id]) m_val[id] = lv;
            else x.le = 1;
        end else if (e) begin
            if (m_val[id] == m_lim[id]) begin
                m_val[id] = 0;
                x.w = 1;
            end else begin
                m_val[id] = m_val[id] + 1;
            end
        end
        x.t = m_val[id] / 10;
        x.u = m_val[id] % 10;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        if (x.id == 0) begin
            check("tens_a",  8'(tens_a),  8'(x.t));
            check("units_a", 8'(units_a), 8'(x.u));
            check("wrap_a",  8'(wrap_a),  8'(x.w));
            check("lerr_a",  8'(lerr_a),  8'(x.le));
            $display("A r=%0b e=%0b l=%0b ld=%0d/%0d -> %0d%0d w=%0b le=%0b",
                     r, e, l, t, u, tens_a, units_a, wrap_a, lerr_a);
        end else begin
            check("tens_b",  8'(tens_b),  8'(x.t));
            check("units_b", 8'(units_b), 8'(x.u));
            check("wrap_b",  8'(wrap_b),  8'(x.w));
            check("lerr_b",  8'(lerr_b),  8'(x.le));
            $display("B r=%0b e=%0b l=%0b ld=%0d/%0d -> %0d%0d w=%0b le=%0b",
                     r, e, l, t, u, tens_b, units_b, wrap_b, lerr_b);
        end
    endtask

    initial begin
        rst_a = 1; en_a = 0; ld_a = 0; lt_a = 0; lu_a = 0;
        rst_b = 1; en_b = 0; ld_b = 0; lt_b = 0; lu_b = 0;
        @(negedge clk);

        apply(1, 1, 0, 0, 0, 0);
        // Reset with enable high for two cycles, then count from 00.
        apply(0, 1, 1, 0, 0, 0);
        apply(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 60; i++) apply(0, 0, 1, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);

        // Load overrides enable, then two increments to wrap.
        apply(0, 0, 1, 1, 4'd5, 4'd8);
        apply(0, 0, 1, 0, 0, 0);
        apply(0, 0, 1, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);

        // Rejected loads: above limit, non-BCD units, non-BCD tens, 99.
        apply(0, 0, 1, 1, 4'd6, 4'd0);
        apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 4'd2, 4'd10);
        apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 4'd12, 4'd1);
        apply(0, 0, 0, 1, 4'd9, 4'd9);
        apply(0, 0, 0, 0, 0, 0);

        // Reset beats a simultaneous load and enable.
        apply(0, 0, 0, 1, 4'd3, 4'd7);
        apply(0, 1, 1, 1, 4'd1, 4'd2);
        apply(0, 0, 0, 1, 4'd5, 4'd9);
        apply(0, 0, 1, 0, 0, 0);
        apply(0, 0, 1, 1, 4'd0, 4'd9);
        apply(0, 0, 1, 0, 0, 0);

        // Limit 35 instance: enable every other cycle, wraps 35 -> 00.
        for (int i = 0; i < 80; i++) apply(1, 0, (i % 2) == 0, 0, 0, 0);
        apply(1, 0, 0, 1, 4'd3, 4'd6);
        apply(1, 0, 1, 1, 4'd2, 4'd9);
        apply(1, 0, 1, 0, 0, 0);
        apply(1, 0, 0, 1, 4'd3, 4'd5);
        apply(1, 0, 1, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);

        if (sb_q.size() != 0) check("sb_drain", 8'(sb_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/contador_bcd_asc_lim.md
# contador_bcd_asc_lim

Two-digit BCD up-counter with programmable wrap limit, parallel load, count enable and cascade carry. It counts upward from 00 to a parameterised limit (default 59), then wraps to 00. It is the ascending counterpart of the team's descending limited counters and serves as the minutes/seconds-style display source and cascade stage in the timing datapath. Outputs drive the 7-segment decoders directly.

## Interface
- MAX_TENS, default 5: tens digit of the wrap limit, legal range 0–9.
- MAX_UNITS, default 9: units digit of the wrap limit, legal range 0–9.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- enable  in  1  count enable; one increment per cycle while high.
- load  in  1  parallel-load strobe.
- load_tens  in  4  BCD tens value to load.
- load_units  in  4  BCD units value to load.
- tens  out  4  current tens digit, registered.
- units  out  4  current units digit, registered.
- tc  out  1  terminal count, combinational: enable && count == limit; cascade carry into the next stage's enable.
- wrap  out  1  registered one-cycle pulse; high in the cycle the count first shows 00 after wrapping from the limit.
- load_err  out  1  registered one-cycle pulse; high in the cycle after a rejected load.

## Operation
- Priority, evaluated each rising edge: reset > load > enable > hold.
- Reset:
  - tens = 0, units = 0, wrap = 0, load_err = 0.
  - tc = 0, because tc requires enable and the count is not at the limit (unless the limit is 00; see boundaries).
- Load:
  - Valid when load_units ≤ 9, load_tens ≤ 9, and {load_tens, load_units} ≤ {MAX_TENS, MAX_UNITS} in BCD order.
  - Valid load: count takes the loaded value; load_err = 0.
  - Invalid load: count holds; load_err = 1 for one cycle.
  - Load always overrides enable in the same cycle. No increment occurs and wrap = 0.
- Enable, with no load and no reset:
  - If count == limit: next count = 00 and wrap = 1.
  - Else if units == 9: units = 0 and tens = tens + 1.
  - Else: units = units + 1.
- Hold: count unchanged; wrap = 0 and load_err = 0.
- Arithmetic is BCD per digit on 4 bits. Non-BCD codes never appear on tens or units.
- Boundaries:
  - A limit of 00 makes the counter stay at 00. With enable high, tc is constantly high and wrap pulses every cycle.
  - A limit with MAX_UNITS < 9 wraps only at the exact limit. Intermediate tens values still carry at units 9, e.g. limit 35: 29 → 30, 35 → 00.
  - Reset mid-count takes effect on the next edge, regardless of load or enable.

## Timing
- Count latency: one cycle from enable or load sampled high to the updated tens/units.
- wrap and load_err are registered and aligned with the edge that produced the new count (or the rejected load).
- tc is combinational from enable and the registered count. No clock-cycle latency, so a downstream stage driven by tc increments on the same edge this stage wraps.
- No multicycle paths; all outputs are stable within the same clock domain.

## Structure
- Shared package holds:
  - BCD_W = 4 and BCD_MAX = 4'd9.
  - A function that checks a BCD digit is valid (≤ 9).
  - A function that compares two-digit BCD values.
- Sub-module contador_bcd_digito, instantiated twice (units, tens):
  - Inputs: clk, reset, inc, clr, ld, d.
  - Outputs: q, at9.
  - Wraps 9 → 0 on inc; clr forces 0.
- Top level contains limit detection, load validation, priority logic, and the wrap/load_err/tc generation.

## Test plan
- Reset high for 2 cycles with enable = 1 → tens/units = 0/0, wrap = 0, load_err = 0. After reset drops, the count reaches 01 after 1 cycle.
- Continuous enable from 00 for 60 cycles → passes 09 → 10 carry and 58 → 59. At 59, tc = 1. The next edge gives 00 with wrap = 1 for exactly one cycle.
- Load 5/8 with enable = 1 in the same cycle → count = 58, with no increment. Two further enables → 59, then 00 with a wrap pulse.
- Load 6/0 (above the 59 limit), then load 2/10 (non-BCD) → count unchanged, and load_err pulses once for each.
- Reset asserted at count 37 together with load 1/2 → count = 00 on the next edge; the load is ignored.
- Limit override MAX_TENS = 3, MAX_UNITS = 5, enable toggled every other cycle → count advances only on enabled edges, and the sequence wraps 35 → 00.
